// File: rtl/uart_efect_rx_if.sv
// uart_efect_rx_if: bundles the serial line and the effect-code outputs of the
// UART effect receiver. The slave modport is the receiver side. The master
// modport is the side that drives rx and watches the decoded effect code.
interface uart_efect_rx_if;
   logic       rx;
   logic [6:0] efect;
   logic       efect_valid;
   logic       frame_err;

   modport master (output rx, input efect, input efect_valid, input frame_err);
   modport slave  (input rx, output efect, output efect_valid, output frame_err);
endinterface

// File: rtl/uart_efect_rx.sv
// uart_efect_rx: receives UART bytes with 16x oversampling and keeps the last
// ASCII '0'..'5' byte received on efect, which feeds the effect one-hot decoder.
// All other bytes are discarded.
// By default the frame format is 8N1. When EFECT_PARITY_EN is defined, the
// frame format is 8E1 and a parity mismatch raises frame_err.
module uart_efect_rx #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input logic            clk,
   input logic            rst_n,
   uart_efect_rx_if.slave bus
);
   localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
`ifdef EFECT_PARITY_EN
      PARITY    = 3'd5,
`endif
      WAIT_IDLE = 3'd4
   } state_t;

   // Only ASCII '0'..'5' are effect codes. A byte with bit 7 set falls outside this range.
   function automatic logic code_ok(input logic [7:0] b);
      return (b >= 8'h30) && (b <= 8'h35);
   endfunction

`ifdef EFECT_PARITY_EN
   // The data bits and the parity bit together must hold an even number of ones.
   function automatic logic even_parity_ok(input logic [7:0] b, input logic p);
      return ((^b) ^ p) == 1'b0;
   endfunction
`endif

   logic [1:0]    rst_sync_r;
   logic          rst_int_n_s;
   logic [1:0]    rx_sync_r;
   logic          rxs_s;
   logic [DW-1:0] div_r;
   logic          tick_s;
   logic          restart_s;
   state_t        state_r, state_n;
   logic [3:0]    cnt_r, cnt_n;
   logic [2:0]    bit_r, bit_n;
   logic [7:0]    shift_r, shift_n;
   logic          load_s, err_s;
   logic [6:0]    efect_r;
   logic          efect_valid_r, frame_err_r;

   // Reset asserts immediately and is released on a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_r <= 2'b00;
      else        rst_sync_r <= {rst_sync_r[0], 1'b1};
   end
   assign rst_int_n_s = rst_sync_r[1];

   // Two-flop synchroniser for the asynchronous serial line.
   always_ff @(posedge clk or negedge rst_int_n_s) begin
      if (!rst_int_n_s) rx_sync_r <= 2'b11;
      else              rx_sync_r <= {rx_sync_r[0], bus.rx};
   end
   assign rxs_s = rx_sync_r[1];

   assign tick_s    = (div_r == DIV_LAST);
   assign restart_s = (state_r == IDLE) && !rxs_s;

   // Oversample tick divider. It is realigned to the falling edge of each start bit.
   always_ff @(posedge clk or negedge rst_int_n_s) begin
      if (!rst_int_n_s)  div_r <= '0;
      else if (restart_s) div_r <= '0;
      else if (tick_s)    div_r <= '0;
      else                div_r <= div_r + DW'(1);
   end

   // FSM state and datapath registers.
   always_ff @(posedge clk or negedge rst_int_n_s) begin
      if (!rst_int_n_s) begin
         state_r <= IDLE;
         cnt_r   <= 4'd0;
         bit_r   <= 3'd0;
         shift_r <= 8'h00;
      end else begin
         state_r <= state_n;
         cnt_r   <= cnt_n;
         bit_r   <= bit_n;
         shift_r <= shift_n;
      end
   end

   // Next-state logic. cnt_r counts oversample ticks within the current bit.
   always_comb begin
      state_n = state_r;
      cnt_n   = cnt_r;
      bit_n   = bit_r;
      shift_n = shift_r;
      load_s  = 1'b0;
      err_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (!rxs_s) begin
               state_n = START;
               cnt_n   = 4'd0;
            end else begin
               state_n = IDLE;
            end
         end
         START: begin
            if (tick_s && (cnt_r == 4'd7)) begin
               cnt_n = 4'd0;
               bit_n = 3'd0;
               if (rxs_s) state_n = IDLE;
               else       state_n = DATA;
            end else if (tick_s) begin
               cnt_n = cnt_r + 4'd1;
            end else begin
               cnt_n = cnt_r;
            end
         end
         DATA: begin
            if (tick_s && (cnt_r == 4'd15)) begin
               shift_n[bit_r] = rxs_s;
               cnt_n          = 4'd0;
               if (bit_r == 3'd7) begin
`ifdef EFECT_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end else begin
                  bit_n = bit_r + 3'd1;
               end
            end else if (tick_s) begin
               cnt_n = cnt_r + 4'd1;
            end else begin
               cnt_n = cnt_r;
            end
         end
`ifdef EFECT_PARITY_EN
         PARITY: begin
            if (tick_s && (cnt_r == 4'd15)) begin
               cnt_n = 4'd0;
               if (even_parity_ok(shift_r, rxs_s)) begin
                  state_n = STOP;
               end else begin
                  err_s   = 1'b1;
                  state_n = WAIT_IDLE;
               end
            end else if (tick_s) begin
               cnt_n = cnt_r + 4'd1;
            end else begin
               cnt_n = cnt_r;
            end
         end
`endif
         STOP: begin
            if (tick_s && (cnt_r == 4'd15)) begin
               cnt_n = 4'd0;
               if (rxs_s) begin
                  load_s  = code_ok(shift_r);
                  state_n = IDLE;
               end else begin
                  err_s   = 1'b1;
                  state_n = WAIT_IDLE;
               end
            end else if (tick_s) begin
               cnt_n = cnt_r + 4'd1;
            end else begin
               cnt_n = cnt_r;
            end
         end
         WAIT_IDLE: begin
            // A low line restarts the one-bit-time idle requirement.
            if (!rxs_s) begin
               cnt_n = 4'd0;
            end else if (tick_s && (cnt_r == 4'd15)) begin
               cnt_n   = 4'd0;
               state_n = IDLE;
            end else if (tick_s) begin
               cnt_n = cnt_r + 4'd1;
            end else begin
               cnt_n = cnt_r;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = 4'd0;
         end
      endcase
   end

   // Registered outputs. efect changes only when a byte is accepted.
   always_ff @(posedge clk or negedge rst_int_n_s) begin
      if (!rst_int_n_s) begin
         efect_r       <= 7'd48;
         efect_valid_r <= 1'b0;
         frame_err_r   <= 1'b0;
      end else begin
         if (load_s) efect_r <= shift_r[6:0];
         efect_valid_r <= load_s;
         frame_err_r   <= err_s;
      end
   end

   assign bus.efect       = efect_r;
   assign bus.efect_valid = efect_valid_r;
   assign bus.frame_err   = frame_err_r;
endmodule

// File: tb/tb_uart_efect_rx.sv
// tb_uart_efect_rx: testbench for uart_efect_rx. It sends a table of frames,
// then a few hand-written corner-case sequences, then random frames. Each
// result is compared with a frame-level reference model.
module tb_uart_efect_rx;
   localparam int CLK_HZ   = 614_400;
   localparam int BAUD     = 9600;
   localparam int DIV      = CLK_HZ / (BAUD * 16);
   localparam int BIT_CLKS = 16 * DIV;
`ifdef EFECT_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   uart_efect_rx_if bus_if ();

   uart_efect_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int valid_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;
   int range_bad = 0;
   int last_valid_cyc = 0;
   logic [6:0] model_ef;

   // cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   // output pulse monitor
   always @(negedge clk) begin
      if (bus_if.efect_valid === 1'b1) begin
         valid_cnt      <= valid_cnt + 1;
         last_valid_cyc <= cyc;
      end
      if (bus_if.frame_err === 1'b1) err_cnt <= err_cnt + 1;
      if (bus_if.efect_valid === 1'b1 && bus_if.frame_err === 1'b1) both_cnt <= both_cnt + 1;
      if (!(bus_if.efect >= 7'd48 && bus_if.efect <= 7'd53)) range_bad <= range_bad + 1;
   end

   // watchdog
   initial begin
      #(10 * 80_000);
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input int got, input int exp);
      checks = checks + 1;
      if (got != exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic hold_bit(input logic v, input int clks);
      bus_if.rx = v;
      repeat (clks) @(negedge clk);
   endtask

   // Reference: the decision made for one whole frame.
   function automatic void model(input logic [7:0] b, input bit stop_ok, input bit par_ok,
                                 inout logic [6:0] ef, output int ev, output int ee);
      ev = 0;
      ee = 0;
      if (PAR_BITS == 1 && !par_ok) ee = 1;
      else if (!stop_ok)            ee = 1;
      else if (b >= 8'd48 && b <= 8'd53) begin
         ev = 1;
         ef = b[6:0];
      end
   endfunction

   task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit par_good,
                             input int idle_bits, output int start_cyc);
      start_cyc = cyc;
      hold_bit(1'b0, BIT_CLKS);
      for (int i = 0; i < 8; i++) hold_bit(b[i], BIT_CLKS);
      if (PAR_BITS == 1) hold_bit((^b) ^ !par_good, BIT_CLKS);
      hold_bit(stop_bit, BIT_CLKS);
      hold_bit(1'b1, idle_bits * BIT_CLKS);
   endtask

   task automatic apply_frame(input string name, input logic [7:0] b, input bit stop_bit,
                              input bit par_good, input int idle_bits,
                              input int ev, input int ee, input logic [6:0] ef);
      int v0, e0, sc;
      v0 = valid_cnt;
      e0 = err_cnt;
      send_frame(b, stop_bit, par_good, idle_bits, sc);
      #1;
      check({name, "_valid"}, valid_cnt - v0, ev);
      check({name, "_ferr"}, err_cnt - e0, ee);
      check({name, "_efect"}, int'(bus_if.efect), int'(ef));
      if (ev == 1) begin
         check({name, "_latency_ok"},
               int'((last_valid_cyc - sc) > (9 + PAR_BITS) * BIT_CLKS &&
                    (last_valid_cyc - sc) < (10 + PAR_BITS) * BIT_CLKS), 1);
      end
   endtask

   typedef struct {
      logic [7:0] b;
      bit         stop;
      int         idle;
      int         ev;
      int         ee;
      logic [6:0] ef;
   } vec_t;

   vec_t vecs [10];

   initial begin
      int v0, e0, sc, ev, ee;
      logic [7:0] rb;
      bit rs, rp;

      vecs[0] = '{8'h33, 1'b1, 2, 1, 0, 7'd51};
      vecs[1] = '{8'h41, 1'b1, 2, 0, 0, 7'd51};
      vecs[2] = '{8'hB2, 1'b1, 2, 0, 0, 7'd51};
      vecs[3] = '{8'h35, 1'b0, 1, 0, 1, 7'd51};
      vecs[4] = '{8'h30, 1'b1, 2, 1, 0, 7'd48};
      vecs[5] = '{8'h30, 1'b1, 2, 1, 0, 7'd48};
      vecs[6] = '{8'h35, 1'b1, 2, 1, 0, 7'd53};
      vecs[7] = '{8'h2F, 1'b1, 2, 0, 0, 7'd53};
      vecs[8] = '{8'h36, 1'b1, 2, 0, 0, 7'd53};
      vecs[9] = '{8'hB3, 1'b1, 2, 0, 0, 7'd53};

      // Reset with the line idle.
      bus_if.rx = 1'b1;
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      check("in_reset_efect", int'(bus_if.efect), 48);
      check("in_reset_valid", int'(bus_if.efect_valid), 0);
      check("in_reset_ferr", int'(bus_if.frame_err), 0);
      rst_n = 1'b1;
      repeat (3 * BIT_CLKS) @(negedge clk);
      #1;
      check("idle_efect", int'(bus_if.efect), 48);
      check("idle_valid_pulses", valid_cnt, 0);
      check("idle_ferr_pulses", err_cnt, 0);

      // Table of frames.
      for (int i = 0; i < 10; i++) begin
         apply_frame($sformatf("vec%0d", i), vecs[i].b, vecs[i].stop, 1'b1, vecs[i].idle,
                     vecs[i].ev, vecs[i].ee, vecs[i].ef);
      end

      // Start-bit glitch of 4 ticks is ignored.
      v0 = valid_cnt;
      e0 = err_cnt;
      hold_bit(1'b0, 4 * DIV);
      hold_bit(1'b1, 2 * BIT_CLKS);
      #1;
      check("glitch_valid", valid_cnt - v0, 0);
      check("glitch_ferr", err_cnt - e0, 0);
      check("glitch_efect", int'(bus_if.efect), 53);
      apply_frame("after_glitch", 8'h31, 1'b1, 1'b1, 2, 1, 0, 7'd49);

      // Reset during data bit 4 of 8'h32.
      v0 = valid_cnt;
      rb = 8'h32;
      hold_bit(1'b0, BIT_CLKS);
      for (int i = 0; i < 4; i++) hold_bit(rb[i], BIT_CLKS);
      hold_bit(rb[4], BIT_CLKS / 2);
      rst_n = 1'b0;
      #1;
      check("midframe_reset_efect", int'(bus_if.efect), 48);
      hold_bit(1'b1, 10);
      rst_n = 1'b1;
      hold_bit(1'b1, 2 * BIT_CLKS);
      #1;
      check("midframe_reset_no_pulse", valid_cnt - v0, 0);
      apply_frame("after_reset", 8'h34, 1'b1, 1'b1, 2, 1, 0, 7'd52);
      model_ef = 7'd52;

`ifdef EFECT_PARITY_EN
      apply_frame("bad_parity", 8'h31, 1'b1, 1'b0, 2, 0, 1, 7'd52);
`endif

      // Random frames checked against the frame-level model.
      for (int i = 0; i < 20; i++) begin
         if ($urandom_range(0, 1) == 0) rb = 8'h30 + 8'($urandom_range(0, 5));
         else                           rb = 8'($urandom_range(0, 255));
         rs = ($urandom_range(0, 7) != 0);
         rp = (PAR_BITS == 0) || ($urandom_range(0, 7) != 0);
         model(rb, rs, rp, model_ef, ev, ee);
         apply_frame($sformatf("rand%0d_%02h", i, rb), rb, rs, rp, 2, ev, ee, model_ef);
      end

      check("valid_and_ferr_together", both_cnt, 0);
      check("efect_out_of_range", range_bad, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
